// File: rtl/fifo_rr_sched.sv
// Round-robin scheduler draining NUM_REQ 1-deep FIFOs into one output register.
// Define FIFO_RR_SCHED_PRIO_EN to give source 0 strict priority over the rotation.
module fifo_rr_sched #(
    parameter int WIDTH    = 16,
    parameter int NUM_REQ  = 4,
    parameter int SRC_BITS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NUM_REQ-1:0]       src_empty,
    input  logic [NUM_REQ*WIDTH-1:0] src_dout,
    output logic [NUM_REQ-1:0]       src_rd,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [SRC_BITS-1:0]      out_src,
    input  logic                     out_ready
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]          state;
    logic                live;
    logic [SRC_BITS-1:0] rr_ptr;
    logic [SRC_BITS-1:0] pick;
    logic [SRC_BITS-1:0] ptr_next;
    logic [SRC_BITS:0]   sum;
    logic                hit;
    logic                prio_hit;
    logic                slot;
    logic                grant;
    logic [WIDTH-1:0]    words [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign words[i] = src_dout[i*WIDTH +: WIDTH];
    end

    // First non-empty source at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick     = '0;
        hit      = 1'b0;
        prio_hit = 1'b0;
        sum      = '0;
`ifdef FIFO_RR_SCHED_PRIO_EN
        if (!src_empty[0]) begin
            hit      = 1'b1;
            prio_hit = 1'b1;
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (SRC_BITS+1)'(k);
            if (sum >= (SRC_BITS+1)'(NUM_REQ)) begin
                sum = sum - (SRC_BITS+1)'(NUM_REQ);
            end
            if (!hit && !src_empty[sum[SRC_BITS-1:0]]) begin
                hit  = 1'b1;
                pick = sum[SRC_BITS-1:0];
            end
        end
    end

    // live keeps the first cycle after reset release free of reads.
    assign slot  = live && en && (state == IDLE || out_ready);
    assign grant = slot && hit;

    assign ptr_next = (pick == SRC_BITS'(NUM_REQ - 1)) ? '0
                    : pick + 1'b1;

    assign src_rd    = grant ? (NUM_REQ'(1) << pick) : '0;
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            live     <= 1'b0;
            rr_ptr   <= '0;
            out_data <= '0;
            out_src  <= '0;
        end else begin
            live <= 1'b1;
            if (grant) begin
                state    <= HOLD;
                out_data <= words[pick];
                out_src  <= pick;
                if (!prio_hit) begin
                    rr_ptr <= ptr_next;
                end
            end else if (state == HOLD && out_ready) begin
                state <= IDLE;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            if (!$onehot0(src_rd)) begin
                $error("fifo_rr_sched: src_rd has more than one bit set");
            end
            if ((src_rd & src_empty) != '0) begin
                $error("fifo_rr_sched: src_rd hit an empty source");
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Randomized bench for fifo_rr_sched against a queue-level scheduling model.
// Honours FIFO_RR_SCHED_PRIO_EN for the priority scenario.
module tb_fifo_rr_sched;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int SB = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [N-1:0]   src_empty;
    logic [N*W-1:0] src_dout;
    logic [N-1:0]   src_rd;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SB-1:0]  out_src;
    logic           out_ready;

    logic         full [N];
    logic [W-1:0] word [N];

    int checks = 0;
    int errors = 0;

    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_src;
    int           m_ptr;
    bit           m_live;

    fifo_rr_sched #(.WIDTH(W), .NUM_REQ(N), .SRC_BITS(SB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .src_empty (src_empty),
        .src_dout  (src_dout),
        .src_rd    (src_rd),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always_comb begin
        src_empty = '0;
        src_dout  = '0;
        for (int i = 0; i < N; i++) begin
            src_empty[i]      = !full[i];
            src_dout[i*W +: W] = word[i];
        end
    end

    // Which source the scheduler should serve this cycle, -1 for none.
    function automatic int exp_grant();
        if (!rst_n || !en || !m_live) return -1;
        if (m_valid && !out_ready) return -1;
`ifdef FIFO_RR_SCHED_PRIO_EN
        if (full[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (full[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_valid = 0;
        m_data  = '0;
        m_src   = 0;
        m_ptr   = 0;
        m_live  = 0;
    endfunction

    // One clock: check read strobes before the edge, outputs after it.
    task automatic step(output int g);
        logic [N-1:0] rd_exp;
        logic [W-1:0] d;
        @(negedge clk);
        g = exp_grant();
        rd_exp = (g >= 0) ? (N'(1) << g) : '0;
        d = (g >= 0) ? word[g] : '0;
        checks++;
        if (src_rd !== rd_exp) begin
            errors++;
            $display("FAIL src_rd: got %b want %b t=%0t", src_rd, rd_exp, $time);
        end
        @(posedge clk);
        #1;
        m_live = 1;
        if (g >= 0) begin
            m_valid = 1;
            m_data  = d;
            m_src   = g;
            full[g] = 0;
`ifdef FIFO_RR_SCHED_PRIO_EN
            if (g != 0) m_ptr = (g + 1) % N;
`else
            m_ptr = (g + 1) % N;
`endif
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        checks++;
        if (out_valid !== m_valid) begin
            errors++;
            $display("FAIL out_valid: got %b want %b t=%0t", out_valid, m_valid, $time);
        end
        checks++;
        if (out_data !== m_data) begin
            errors++;
            $display("FAIL out_data: got %h want %h t=%0t", out_data, m_data, $time);
        end
        checks++;
        if (out_src !== SB'(m_src)) begin
            errors++;
            $display("FAIL out_src: got %0d want %0d t=%0t", out_src, m_src, $time);
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) full[i] = 0;
    endtask

    task automatic fill(input int i, input logic [W-1:0] v);
        full[i] = 1;
        word[i] = v;
    endtask

    task automatic test_reset();
        int g;
        rst_n = 0;
        en = 1;
        out_ready = 1;
        for (int i = 0; i < N; i++) fill(i, W'($urandom));
        model_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0 || src_rd !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h s=%0d rd=%b want 0", out_valid, out_data, out_src, src_rd);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        step(g);
        checks++;
        if (g != -1) begin
            errors++;
            $display("FAIL reset_release_quiet: model grant %0d want none", g);
        end
    endtask

    task automatic test_sequence();
        int g;
        for (int i = 0; i < N; i++) fill(i, 16'hA000 + W'(i));
        for (int i = 0; i < N; i++) begin
            step(g);
            checks++;
            if (out_src !== SB'(i) || out_valid !== 1'b1 || out_data !== 16'hA000 + W'(i)) begin
                errors++;
                $display("FAIL seq_order: got src %0d d=%h v=%b want src %0d", out_src, out_data, out_valid, i);
            end
        end
        step(g);
    endtask

    task automatic test_wrap();
        int g;
        clear_src();
        out_ready = 1;
        step(g);
        fill(2, 16'h2222);
        step(g);
        fill(2, 16'h2BBB);
        step(g);
        checks++;
        if (out_src !== SB'(2) || out_data !== 16'h2BBB) begin
            errors++;
            $display("FAIL wrap_grant: got src %0d d=%h want 2 2bbb", out_src, out_data);
        end
        fill(3, 16'h3333);
        fill(2, 16'h2CCC);
        step(g);
        checks++;
        if (out_src !== SB'(3)) begin
            errors++;
            $display("FAIL wrap_ptr: got src %0d want 3", out_src);
        end
        clear_src();
        step(g);
    endtask

    task automatic test_stall();
        int g;
        logic [W-1:0] held;
        clear_src();
        fill(1, 16'h1111);
        out_ready = 0;
        step(g);
        held = out_data;
        for (int i = 0; i < N; i++) if (i != 1) fill(i, W'($urandom));
        for (int c = 0; c < 5; c++) begin
            step(g);
            checks++;
            if (out_data !== held || out_src !== SB'(1) || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: got src %0d d=%h want 1 %h", out_src, out_data, held);
            end
        end
        out_ready = 1;
        step(g);
        for (int c = 0; c < 4; c++) step(g);
    endtask

    task automatic test_enable();
        int g;
        for (int i = 0; i < N; i++) fill(i, W'($urandom));
        en = 0;
        for (int c = 0; c < 3; c++) begin
            step(g);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL en_block: got out_valid %b want 0", out_valid);
            end
        end
        en = 1;
        step(g);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL en_resume: got out_valid %b want 1", out_valid);
        end
        out_ready = 0;
        step(g);
        en = 0;
        step(g);
        out_ready = 1;
        step(g);
        en = 1;
    endtask

    task automatic test_async_reset();
        int g;
        for (int i = 0; i < N; i++) fill(i, W'($urandom));
        out_ready = 0;
        step(g);
        step(g);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (out_valid !== 1'b0 || src_rd !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%b rd=%b d=%h want 0", out_valid, src_rd, out_data);
        end
        out_ready = 1;
        @(posedge clk);
        #1;
        rst_n = 1;
        step(g);
        step(g);
        checks++;
        if (out_src !== '0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_ptr: got src %0d v=%b want 0 1", out_src, out_valid);
        end
    endtask

    task automatic test_random();
        int g;
        for (int c = 0; c < 400; c++) begin
            en = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!full[i] && $urandom_range(0, 1) == 1) fill(i, W'($urandom));
            end
            step(g);
        end
        en = 1;
        out_ready = 1;
    endtask

`ifdef FIFO_RR_SCHED_PRIO_EN
    task automatic test_prio();
        int g;
        int hits3 = 0;
        clear_src();
        out_ready = 1;
        step(g);
        fill(3, 16'h3AAA);
        for (int c = 0; c < 8; c++) begin
            fill(0, W'($urandom));
            step(g);
            if (out_valid && out_src == SB'(3)) hits3++;
        end
        checks++;
        if (hits3 != 0) begin
            errors++;
            $display("FAIL prio_starve: source 3 granted %0d times want 0", hits3);
        end
        step(g);
        checks++;
        if (out_src !== SB'(3) || out_data !== 16'h3AAA) begin
            errors++;
            $display("FAIL prio_release: got src %0d d=%h want 3 3aaa", out_src, out_data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_wrap();
        test_stall();
        test_enable();
        test_async_reset();
        test_random();
`ifdef FIFO_RR_SCHED_PRIO_EN
        test_prio();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
